// File: rtl/idct_pkg.sv
// Constants shared by the IDCT pipeline stages: sample width, clip bounds, lane count.
package idct_pkg;
  localparam int unsigned DATA_W   = 25;
  localparam int unsigned LANES    = 4;
  localparam int          CLIP_MAX = 32767;
  localparam int          CLIP_MIN = -32768;
endpackage

// File: rtl/idct_transpose_skew_if.sv
// Column-in / skewed-row-out bus of the transpose buffer.
interface idct_transpose_skew_if
  import idct_pkg::*;
#(
  parameter int unsigned W = DATA_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_d0;
  logic [W-1:0] in_d1;
  logic [W-1:0] in_d2;
  logic [W-1:0] in_d3;
  logic [W-1:0] out_d1;
  logic [W-1:0] out_d2;
  logic [W-1:0] out_d3;
  logic [W-1:0] out_d4;
  logic [3:0]   out_valid;

  modport master (
    output in_valid, in_d0, in_d1, in_d2, in_d3,
    input  in_ready, out_d1, out_d2, out_d3, out_d4, out_valid
  );

  modport slave (
    input  in_valid, in_d0, in_d1, in_d2, in_d3,
    output in_ready, out_d1, out_d2, out_d3, out_d4, out_valid
  );
endinterface

// File: rtl/skew_delay.sv
// Fixed-depth register chain carrying a data word and its valid bit.
module skew_delay
  import idct_pkg::*;
#(
  parameter int unsigned W     = DATA_W,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_d,
  output logic         out_valid,
  output logic [W-1:0] out_d
);

  logic [W-1:0]     d_q [DEPTH];
  logic [DEPTH-1:0] v_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q[0] <= in_valid;
      d_q[0] <= in_d;
      for (int i = 1; i < DEPTH; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_d     = d_q[DEPTH-1];

endmodule

// File: rtl/idct_transpose_skew.sv
// Ping-pong 4x4 transpose buffer feeding the systolic row IDCT with diagonally skewed lanes.
module idct_transpose_skew
  import idct_pkg::*;
#(
  parameter int unsigned W       = DATA_W,
  parameter bit          CLIP_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  idct_transpose_skew_if.slave bus
);

  localparam logic signed [W-1:0] SAT_HI = W'(CLIP_MAX);
  localparam logic signed [W-1:0] SAT_LO = W'(CLIP_MIN);

  function automatic logic [W-1:0] sat(input logic [W-1:0] x);
    logic signed [W-1:0] s;
    s = signed'(x);
    if (!CLIP_EN) return x;
    if (s > SAT_HI) return SAT_HI;
    if (s < SAT_LO) return SAT_LO;
    return x;
  endfunction

  logic [W-1:0]       in_d   [LANES];
  logic [W-1:0]       mem    [2][LANES][LANES];
  logic [W-1:0]       row_d  [LANES];
  logic [W-1:0]       lane_d [LANES];
  logic [LANES-1:0]   lane_v;

  logic       wr_bank, wr_bank_n;
  logic [1:0] wr_col, wr_col_n;
  logic       wr_full, wr_full_n;
  logic       rd_busy, rd_busy_n;
  logic [1:0] rd_row, rd_row_n;
  logic       ready_q, ready_n;
  logic       accept, fill, rd_last, full_now, swap, rd_bank;

  assign in_d[0] = bus.in_d0;
  assign in_d[1] = bus.in_d1;
  assign in_d[2] = bus.in_d2;
  assign in_d[3] = bus.in_d3;

  assign accept   = bus.in_valid && ready_q;
  assign fill     = accept && (wr_col == 2'd3);
  assign rd_last  = rd_busy && (rd_row == 2'd3);
  assign full_now = wr_full || fill;
  // A filling bank swaps in on the same edge the reader finishes its last row.
  assign swap     = full_now && (!rd_busy || rd_last);
  assign rd_bank  = ~wr_bank;

  always_comb begin
    wr_bank_n = wr_bank ^ swap;
    wr_col_n  = accept ? wr_col + 2'd1 : wr_col;
    wr_full_n = full_now && !swap;
    rd_busy_n = swap || (rd_busy && !rd_last);
    rd_row_n  = rd_row;
    if (swap)         rd_row_n = 2'd0;
    else if (rd_busy) rd_row_n = rd_row + 2'd1;
    ready_n   = !(wr_full_n && rd_busy_n);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank <= 1'b0;
      wr_col  <= 2'd0;
      wr_full <= 1'b0;
      rd_busy <= 1'b0;
      rd_row  <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      wr_bank <= wr_bank_n;
      wr_col  <= wr_col_n;
      wr_full <= wr_full_n;
      rd_busy <= rd_busy_n;
      rd_row  <= rd_row_n;
      ready_q <= ready_n;
    end
  end

  // Bank storage needs no reset; contents are only read after being written.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < LANES; k++) mem[wr_bank][k][wr_col] <= sat(in_d[k]);
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) row_d[k] = '0;
    if (rd_busy) begin
      for (int k = 0; k < LANES; k++) row_d[k] = mem[rd_bank][rd_row][k];
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    skew_delay #(.W(W), .DEPTH(k + 1)) u_dly (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (rd_busy),
      .in_d      (row_d[k]),
      .out_valid (lane_v[k]),
      .out_d     (lane_d[k])
    );
  end

  assign bus.in_ready  = ready_q;
  assign bus.out_d1    = lane_d[0];
  assign bus.out_d2    = lane_d[1];
  assign bus.out_d3    = lane_d[2];
  assign bus.out_d4    = lane_d[3];
  assign bus.out_valid = lane_v;

endmodule

// File: tb/tb_idct_transpose_skew.sv
// Scoreboard bench for idct_transpose_skew: clipping and non-clipping instances driven in lockstep.
module tb_idct_transpose_skew;

  localparam int unsigned W = idct_pkg::DATA_W;

  typedef struct {
    int val;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  idct_transpose_skew_if #(.W(W)) b0 ();
  idct_transpose_skew_if #(.W(W)) b1 ();

  idct_transpose_skew #(.W(W), .CLIP_EN(1'b1)) dut_clip (.clk(clk), .reset(reset), .bus(b0));
  idct_transpose_skew #(.W(W), .CLIP_EN(1'b0)) dut_raw  (.clk(clk), .reset(reset), .bus(b1));

  logic         in_valid;
  logic [W-1:0] din [4];
  logic [W-1:0] od  [2][4];
  logic [3:0]   ov  [2];
  logic         rdy [2];

  assign b0.in_valid = in_valid;
  assign b0.in_d0 = din[0];
  assign b0.in_d1 = din[1];
  assign b0.in_d2 = din[2];
  assign b0.in_d3 = din[3];
  assign b1.in_valid = in_valid;
  assign b1.in_d0 = din[0];
  assign b1.in_d1 = din[1];
  assign b1.in_d2 = din[2];
  assign b1.in_d3 = din[3];

  assign od[0][0] = b0.out_d1;
  assign od[0][1] = b0.out_d2;
  assign od[0][2] = b0.out_d3;
  assign od[0][3] = b0.out_d4;
  assign od[1][0] = b1.out_d1;
  assign od[1][1] = b1.out_d2;
  assign od[1][2] = b1.out_d3;
  assign od[1][3] = b1.out_d4;
  assign ov[0] = b0.out_valid;
  assign ov[1] = b1.out_valid;
  assign rdy[0] = b0.in_ready;
  assign rdy[1] = b1.in_ready;

  exp_t q [2][4][$];
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int max_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sx(input logic [W-1:0] x);
    return int'(signed'(x));
  endfunction

  function automatic int clip16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, (1 << 25) - 1)) - (1 << 24);
  endfunction

  task automatic chk(input string name, input int d, input int k, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s dut%0d lane%0d cyc=%0d got=%0d expected=%0d", name, d, k + 1, cyc, got, exp);
    end
  endtask

  // Reference model: a block is four accepted columns; row r of lane k is X[r][k],
  // emitted after edge s+1+r+k where s is when the block can start reading.
  initial begin : model
    int blk [4][4];
    int ncol;
    int last_s;
    int s;
    exp_t e;
    ncol = 0;
    last_s = -100;
    forever begin
      @(negedge clk);
      if (reset) begin
        ncol = 0;
        last_s = -100;
        for (int d = 0; d < 2; d++)
          for (int k = 0; k < 4; k++) q[d][k].delete();
      end else if (in_valid && rdy[0]) begin
        for (int k = 0; k < 4; k++) blk[k][ncol] = sx(din[k]);
        ncol++;
        if (ncol == 4) begin
          s = cyc + 1;
          if (last_s + 4 > s) s = last_s + 4;
          last_s = s;
          for (int r = 0; r < 4; r++)
            for (int k = 0; k < 4; k++) begin
              e.t = s + 1 + r + k;
              e.val = clip16(blk[r][k]);
              q[0][k].push_back(e);
              e.val = blk[r][k];
              q[1][k].push_back(e);
            end
          ncol = 0;
        end
      end
    end
  end

  initial begin : monitor
    bit prev_rst;
    int run;
    exp_t e;
    prev_rst = 1'b1;
    run = 0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (reset) begin
          chk("reset_ready", d, 0, int'(rdy[d]), 0);
          for (int k = 0; k < 4; k++) begin
            chk("reset_valid", d, k, int'(ov[d][k]), 0);
            chk("reset_data", d, k, sx(od[d][k]), 0);
          end
        end else begin
          if (!prev_rst) chk("in_ready_high", d, 0, int'(rdy[d]), 1);
          for (int k = 0; k < 4; k++) begin
            if (ov[d][k]) begin
              if (q[d][k].size() == 0) begin
                chk("spurious_valid", d, k, int'(ov[d][k]), 0);
              end else begin
                e = q[d][k].pop_front();
                chk("lane_data", d, k, sx(od[d][k]), e.val);
                chk("lane_time", d, k, cyc, e.t);
              end
            end else begin
              chk("idle_data_zero", d, k, sx(od[d][k]), 0);
              if (q[d][k].size() > 0 && q[d][k][0].t < cyc) begin
                chk("missing_valid", d, k, int'(ov[d][k]), 1);
                void'(q[d][k].pop_front());
              end
            end
          end
        end
      end
      if (!reset && ov[0][0]) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      prev_rst = reset;
    end
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int v0, input int v1, input int v2, input int v3);
    int n;
    bit acc;
    in_valid = 1'b1;
    din[0] = W'(v0);
    din[1] = W'(v1);
    din[2] = W'(v2);
    din[3] = W'(v3);
    n = 0;
    forever begin
      acc = rdy[0];
      @(posedge clk);
      #1;
      n++;
      if (acc) break;
      if (n > 50) begin
        chk("send_timeout", 0, 0, int'(rdy[0]), 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_rnd();
    send(rnd(), rnd(), rnd(), rnd());
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
  endtask

  function automatic bit all_empty();
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++)
        if (q[d][k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin : stimulus
    int n;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) din[k] = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle(1);

    for (int c = 0; c < 4; c++) send(4 * c, 4 * c + 1, 4 * c + 2, 4 * c + 3);
    idle(12);

    for (int i = 0; i < 12; i++) send_rnd();
    idle(12);

    send(40000, -40000, 32767, -32768);
    send(-40000, 32767, -32768, 40000);
    send(32767, -32768, 40000, -40000);
    send(-32768, 40000, -40000, 32767);
    idle(12);

    send(100, 101, 102, 103);
    idle(2);
    send(104, 105, 106, 107);
    send(108, 109, 110, 111);
    idle(1);
    send(112, 113, 114, 115);
    idle(12);

    for (int c = 0; c < 3; c++) send(900 + c, 910 + c, 920 + c, 930 + c);
    do_reset(2);
    idle(1);
    for (int c = 0; c < 4; c++) send(200 + 4 * c, 201 + 4 * c, 202 + 4 * c, 203 + 4 * c);
    idle(12);

    for (int i = 0; i < 4; i++) send_rnd();
    idle(2);
    do_reset(2);
    idle(1);
    for (int i = 0; i < 4; i++) send_rnd();
    idle(12);

    for (int i = 0; i < 32; i++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      send_rnd();
    end

    n = 0;
    while (n < 200 && !all_empty()) begin
      @(posedge clk);
      n++;
    end
    idle(2);
    for (int d = 0; d < 2; d++)
      for (int k = 0; k < 4; k++) chk("drained", d, k, q[d][k].size(), 0);
    chk("lane1_run_ge_12", 0, 0, int'(max_run >= 12), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
